// File: rtl/note_game_pkg.sv
// Shared types and constants for the note-memory game.
// Covers note code width, silence code, input-encoder states and index-to-note mapping.
package note_game_pkg;

    localparam int NOTE_W = 4;
    localparam logic [NOTE_W-1:0] NOTE_SILENCE = 4'd0;

    typedef enum logic [1:0] {
        ENC_IDLE,
        ENC_PEND,
        ENC_HELD
    } enc_state_t;

    // Button index i carries note code i+1; code 0 is reserved for silence.
    function automatic logic [NOTE_W-1:0] note_of_index(input int i);
        return NOTE_W'(i + 1);
    endfunction

endpackage

// File: rtl/key_debounce.sv
// One push-button: a 2-FF synchroniser, polarity normalisation (1 = pressed) and a
// level debouncer that accepts a change only after it has held steady long enough.
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter bit KEY_ACTIVE_LOW  = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic stable
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             meta;
    logic             synced;
    logic             level;
    logic [CNT_W-1:0] count;

    assign level = KEY_ACTIVE_LOW ? ~synced : synced;

    // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta   <= 1'b0;
            synced <= 1'b0;
            stable <= 1'b0;
            count  <= '0;
        end else begin
            meta   <= raw;
            synced <= meta;
            if (level == stable) begin
                count <= '0;
            end else if (count == CNT_LAST) begin
                stable <= level;
                count  <= '0;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/note_key_encoder.sv
// Input stage of the note-memory game.
// Debounces the note buttons, priority-encodes them, and issues one answer strobe per press.
module note_key_encoder
    import note_game_pkg::*;
#(
    parameter int NUM_KEYS        = 8,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter bit KEY_ACTIVE_LOW  = 1'b1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_KEYS-1:0] key_raw,
    input  logic                accept,
    output logic [NOTE_W-1:0]   answer,
    output logic                answer_enable,
    output logic                key_active,
    output logic [NOTE_W-1:0]   echo_code,
    output logic                pending
);

    logic [NUM_KEYS-1:0] stable;
    logic [NOTE_W-1:0]   enc_code;
    logic [NOTE_W-1:0]   cap_code;
    enc_state_t          state;

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
        key_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .KEY_ACTIVE_LOW (KEY_ACTIVE_LOW)
        ) u_debounce (
            .clk   (clk),
            .reset (reset),
            .raw   (key_raw[i]),
            .stable(stable[i])
        );
    end

    // NOTE: default assignment first so no path through always_comb leaves enc_code unassigned (no latch).
    always_comb begin
        enc_code = NOTE_SILENCE;
        // Scan high to low so the lowest pressed index is written last and wins.
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (stable[i]) enc_code = note_of_index(i);
        end
    end

    assign echo_code  = enc_code;
    assign key_active = |stable;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= ENC_IDLE;
            cap_code      <= NOTE_SILENCE;
            answer        <= NOTE_SILENCE;
            answer_enable <= 1'b0;
            pending       <= 1'b0;
        end else begin
            answer_enable <= 1'b0;
            case (state)
                ENC_IDLE: begin
                    if (key_active) begin
                        cap_code <= enc_code;
                        pending  <= 1'b1;
                        state    <= ENC_PEND;
                    end
                end
                ENC_PEND: begin
                    // The captured code is delivered even if the key was released meanwhile.
                    if (accept) begin
                        answer        <= cap_code;
                        answer_enable <= 1'b1;
                        pending       <= 1'b0;
                        state         <= key_active ? ENC_HELD : ENC_IDLE;
                    end
                end
                ENC_HELD: begin
                    if (!key_active) state <= ENC_IDLE;
                end
                default: begin
                    pending <= 1'b0;
                    state   <= ENC_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_note_key_encoder.sv
// Directed bench for note_key_encoder with short debounce; strobes are scored against
// a queue of expected codes filled as each press is driven.
module tb_note_key_encoder;

    localparam int NUM_KEYS = 8;
    localparam int DEB      = 4;

    logic                clk = 1'b0;
    logic                reset;
    logic [NUM_KEYS-1:0] key_raw;
    logic                accept;
    logic [3:0]          answer;
    logic                answer_enable;
    logic                key_active;
    logic [3:0]          echo_code;
    logic                pending;

    int         n_cmp    = 0;
    int         n_bad    = 0;
    int         n_strobe = 0;
    int         n_expect = 0;
    logic [7:0] exp_q[$];
    logic       prev_ae;
    logic [3:0] last_answer;
    logic       seen_active;

    note_key_encoder #(
        .NUM_KEYS       (NUM_KEYS),
        .DEBOUNCE_CYCLES(DEB),
        .KEY_ACTIVE_LOW (1'b0)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .key_raw      (key_raw),
        .accept       (accept),
        .answer       (answer),
        .answer_enable(answer_enable),
        .key_active   (key_active),
        .echo_code    (echo_code),
        .pending      (pending)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_press(input logic [7:0] code);
        exp_q.push_back(code);
        n_expect++;
    endtask

    // Waits (bounded) for a strobe sampled just after a rising edge; checks its latency.
    task automatic wait_strobe(input string tag, input int limit, input int exp_cyc);
        int   cyc   = 0;
        logic found = 1'b0;
        while (!found && cyc < limit) begin
            @(posedge clk);
            #1;
            cyc++;
            found = answer_enable;
        end
        check({tag, "_seen"}, 8'(found), 8'd1);
        if (found) check({tag, "_latency"}, 8'(cyc), 8'(exp_cyc));
    endtask

    // Scoreboard monitor: pops an expected code on every strobe, flags back-to-back
    // strobes, and requires answer to stay put on non-strobe cycles.
    always @(negedge clk) begin
        if (reset) begin
            prev_ae     = 1'b0;
            last_answer = answer;
        end else begin
            if (answer_enable) begin
                logic [7:0] exp_code;
                n_strobe++;
                exp_code = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hFF;
                check("sb_answer", 8'(answer), exp_code);
                check("no_back_to_back", 8'(prev_ae), 8'd0);
            end else begin
                check("answer_held", 8'(answer), 8'(last_answer));
            end
            prev_ae     = answer_enable;
            last_answer = answer;
        end
    end

    initial begin
        reset   = 1'b1;
        key_raw = '0;
        accept  = 1'b1;
        tick(3);
        check("rst_answer", 8'(answer), 8'd0);
        check("rst_ae", 8'(answer_enable), 8'd0);
        check("rst_active", 8'(key_active), 8'd0);
        check("rst_echo", 8'(echo_code), 8'd0);
        check("rst_pending", 8'(pending), 8'd0);
        reset = 1'b0;
        tick(3);

        // 1: single key, raw edge to strobe = DEB+2 debounce + 2 FSM cycles
        expect_press(8'd3);
        key_raw = 8'h04;
        wait_strobe("t1", 30, DEB + 4);
        check("t1_answer", 8'(answer), 8'd3);
        check("t1_echo", 8'(echo_code), 8'd3);
        check("t1_active", 8'(key_active), 8'd1);
        tick(12);
        key_raw = '0;
        tick(12);
        check("t1_answer_after", 8'(answer), 8'd3);
        check("t1_echo_rel", 8'(echo_code), 8'd0);
        check("t1_strobes", 8'(n_strobe), 8'(n_expect));

        // 2: bit 0 bouncing every 2 cycles never debounces
        seen_active = 1'b0;
        for (int i = 0; i < 15; i++) begin
            key_raw[0] = ~key_raw[0];
            repeat (2) begin
                tick(1);
                seen_active = seen_active | key_active;
            end
        end
        key_raw = '0;
        repeat (10) begin
            tick(1);
            seen_active = seen_active | key_active;
        end
        check("t2_active_seen", 8'(seen_active), 8'd0);
        check("t2_strobes", 8'(n_strobe), 8'(n_expect));

        // 3: two keys in the same cycle, lower index wins; partial release gives nothing
        expect_press(8'd3);
        key_raw = 8'h14;
        wait_strobe("t3", 30, DEB + 4);
        check("t3_answer", 8'(answer), 8'd3);
        tick(5);
        key_raw = 8'h10;
        tick(15);
        check("t3_echo_upper", 8'(echo_code), 8'd5);
        check("t3_strobes", 8'(n_strobe), 8'(n_expect));
        key_raw = '0;
        tick(12);
        check("t3_active_rel", 8'(key_active), 8'd0);

        // 4: press captured while accept is low survives release
        accept = 1'b0;
        expect_press(8'd8);
        key_raw = 8'h80;
        tick(10);
        key_raw = '0;
        tick(20);
        check("t4_pending", 8'(pending), 8'd1);
        check("t4_no_strobe", 8'(n_strobe), 8'(n_expect - 1));
        check("t4_active", 8'(key_active), 8'd0);
        accept = 1'b1;
        tick(1);
        check("t4_ae", 8'(answer_enable), 8'd1);
        check("t4_answer", 8'(answer), 8'd8);
        check("t4_pending_drop", 8'(pending), 8'd0);
        tick(1);
        check("t4_ae_single", 8'(answer_enable), 8'd0);
        tick(5);

        // 5: reset in the middle of a hold; the still-held key is a fresh press afterwards
        key_raw = 8'h02;
        tick(4);
        reset = 1'b1;
        #1;
        check("t5_rst_active", 8'(key_active), 8'd0);
        check("t5_rst_pending", 8'(pending), 8'd0);
        check("t5_rst_answer", 8'(answer), 8'd0);
        tick(3);
        check("t5_rst_echo", 8'(echo_code), 8'd0);
        check("t5_rst_ae", 8'(answer_enable), 8'd0);
        expect_press(8'd2);
        reset = 1'b0;
        wait_strobe("t5", 30, DEB + 4);
        check("t5_answer", 8'(answer), 8'd2);
        tick(10);
        key_raw = '0;
        tick(12);
        check("t5_strobes", 8'(n_strobe), 8'(n_expect));

        // 6: sequence of presses on bits 0, 5, 0
        for (int k = 0; k < 3; k++) begin
            logic [7:0] code;
            code = (k == 1) ? 8'd6 : 8'd1;
            expect_press(code);
            key_raw = NUM_KEYS'(1) << (code - 1);
            wait_strobe("t6", 30, DEB + 4);
            check("t6_answer", 8'(answer), code);
            tick(4);
            key_raw = '0;
            tick(10);
        end

        check("final_strobes", 8'(n_strobe), 8'(n_expect));
        check("final_queue_empty", 8'(exp_q.size()), 8'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
